// File: rtl/scalar_commit_stage.sv
// scalar_commit_stage: one-entry commit stage after the scalar ALU.
// Resolves branches, writes rf, redirects PC, holds MEM, counts retires.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready ALU-side handshake
//   alu_result, sign_bits, pc, imm, op_kind, branch_cond, rd, rd_write
//                     instruction context captured on accept
//   rf_we/rf_rd/rf_data          register-file write port
//   redirect/redirect_pc         one-cycle PC redirect and flush
//   mem_valid/mem_ready/mem_addr memory-stage handshake
//   instret           64-bit retired-instruction counter
//   err               pulse when an illegal op_kind retires
module scalar_commit_stage #(
  parameter int DATA_LEN       = 32,
  parameter int SCALAR_REG_LEN = 64,
  parameter int REG_INDEX_LEN  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SCALAR_REG_LEN-1:0] alu_result,
  input  logic [1:0]                sign_bits,
  input  logic [DATA_LEN-1:0]       pc,
  input  logic [SCALAR_REG_LEN-1:0] imm,
  input  logic [2:0]                op_kind,
  input  logic [1:0]                branch_cond,
  input  logic [REG_INDEX_LEN-1:0]  rd,
  input  logic                      rd_write,
  output logic                      rf_we,
  output logic [REG_INDEX_LEN-1:0]  rf_rd,
  output logic [SCALAR_REG_LEN-1:0] rf_data,
  output logic                      redirect,
  output logic [DATA_LEN-1:0]       redirect_pc,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [DATA_LEN-1:0]       mem_addr,
  output logic [63:0]               instret,
  output logic                      err
);

  localparam logic [1:0] POS  = 2'd0;
  localparam logic [1:0] ZERO = 2'd1;
  localparam logic [1:0] NEG  = 2'd2;

  localparam logic [2:0] OP_ARITH  = 3'd0;
  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_JAL    = 3'd2;
  localparam logic [2:0] OP_JALR   = 3'd3;
  localparam logic [2:0] OP_MEM    = 3'd4;

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    FLUSH
  } state_t;

  state_t state, state_nx;

  logic                      e_redir;
  logic                      e_we;
  logic                      e_illegal;
  logic                      e_mem;
  logic [REG_INDEX_LEN-1:0]  e_rd;
  logic [DATA_LEN-1:0]       e_target;
  logic [DATA_LEN-1:0]       e_addr;
  logic [SCALAR_REG_LEN-1:0] e_wdata;

  logic                      d_redir;
  logic                      d_we;
  logic                      d_illegal;
  logic                      d_mem;
  logic                      br_taken;
  logic                      wr_ok;
  logic [DATA_LEN-1:0]       d_target;
  logic [DATA_LEN-1:0]       br_target;
  logic [DATA_LEN-1:0]       link;
  logic [SCALAR_REG_LEN-1:0] d_wdata;

  logic full;
  logic retire_now;
  logic redirect_now;
  logic accept;

  assign br_target = pc + imm[DATA_LEN-1:0];
  assign link      = pc + DATA_LEN'(4);
  assign wr_ok     = rd_write && (rd != '0);

  always_comb begin
    br_taken = 1'b0;
    unique case (branch_cond)
      2'd0:    br_taken = (sign_bits == ZERO);
      2'd1:    br_taken = (sign_bits != ZERO);
      2'd2:    br_taken = (sign_bits == NEG);
      2'd3:    br_taken = (sign_bits == POS) ||
                          (sign_bits == ZERO);
      default: br_taken = 1'b0;
    endcase
  end

  // Everything the retire cycle needs is resolved here, at accept,
  // so the held entry only has to be decoded against mem_ready.
  always_comb begin
    d_redir   = 1'b0;
    d_we      = 1'b0;
    d_illegal = 1'b0;
    d_mem     = 1'b0;
    d_target  = '0;
    d_wdata   = alu_result;
    unique case (1'b1)
      (op_kind == OP_ARITH): begin
        d_we = wr_ok;
      end
      (op_kind == OP_BRANCH): begin
        d_redir  = br_taken;
        d_target = br_target;
      end
      (op_kind == OP_JAL): begin
        d_redir  = 1'b1;
        d_target = alu_result[DATA_LEN-1:0];
        d_we     = wr_ok;
        d_wdata  = SCALAR_REG_LEN'(link);
      end
      (op_kind == OP_JALR): begin
        d_redir  = 1'b1;
        d_target = {alu_result[DATA_LEN-1:1], 1'b0};
        d_we     = wr_ok;
        d_wdata  = SCALAR_REG_LEN'(link);
      end
      (op_kind == OP_MEM): begin
        d_mem = 1'b1;
      end
      default: begin
        d_illegal = 1'b1;
      end
    endcase
  end

  // rst gates the live entry so a stalled MEM or pending
  // retire cannot complete a handshake during the reset cycle.
  assign full         = (state == FULL) && !rst;
  assign retire_now   = full && (!e_mem || mem_ready);
  assign redirect_now = retire_now && e_redir;
  assign in_ready     = !rst &&
                        ((state == EMPTY) ||
                         (retire_now && !redirect_now));
  assign accept       = in_valid && in_ready;

  assign rf_we       = retire_now && e_we;
  assign rf_rd       = rf_we ? e_rd : '0;
  assign rf_data     = rf_we ? e_wdata : '0;
  assign redirect    = redirect_now;
  assign redirect_pc = redirect_now ? e_target : '0;
  assign mem_valid   = full && e_mem;
  assign mem_addr    = mem_valid ? e_addr : '0;
  assign err         = retire_now && e_illegal;

  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY: begin
        if (accept) state_nx = FULL;
      end
      FULL: begin
        if (redirect_now)
          state_nx = FLUSH;
        else if (retire_now)
          state_nx = accept ? FULL : EMPTY;
      end
      FLUSH: begin
        state_nx = EMPTY;
      end
      default: begin
        state_nx = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= '0;
    end else if (retire_now && !e_illegal) begin
      instret <= instret + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_redir   <= 1'b0;
      e_we      <= 1'b0;
      e_illegal <= 1'b0;
      e_mem     <= 1'b0;
      e_rd      <= '0;
      e_target  <= '0;
      e_addr    <= '0;
      e_wdata   <= '0;
    end else if (accept) begin
      e_redir   <= d_redir;
      e_we      <= d_we;
      e_illegal <= d_illegal;
      e_mem     <= d_mem;
      e_rd      <= rd;
      e_target  <= d_target;
      e_addr    <= alu_result[DATA_LEN-1:0];
      e_wdata   <= d_wdata;
    end
  end

endmodule

// File: tb/tb_scalar_commit_stage.sv
// tb_scalar_commit_stage: scoreboard bench for scalar_commit_stage.
// Expected retire events are queued at drive time, popped on strobes.
module tb_scalar_commit_stage;

  localparam logic [1:0] S_POS  = 2'd0;
  localparam logic [1:0] S_ZERO = 2'd1;
  localparam logic [1:0] S_NEG  = 2'd2;

  localparam logic [2:0] OP_ARITH  = 3'd0;
  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_JAL    = 3'd2;
  localparam logic [2:0] OP_JALR   = 3'd3;
  localparam logic [2:0] OP_MEM    = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] alu_result;
  logic [1:0]  sign_bits;
  logic [31:0] pc;
  logic [63:0] imm;
  logic [2:0]  op_kind;
  logic [1:0]  branch_cond;
  logic [4:0]  rd;
  logic        rd_write;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [63:0] rf_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [63:0] instret;
  logic        err;

  typedef struct {
    bit          we;
    logic [4:0]  rd;
    logic [63:0] data;
    bit          redir;
    logic [31:0] rpc;
    bit          err;
  } ev_t;

  ev_t         sb[$];
  int          errors = 0;
  int          checks = 0;
  int          we_pulses = 0;
  logic [63:0] exp_instret = 64'd0;

  always #5 clk = ~clk;

  scalar_commit_stage #(
    .DATA_LEN(32),
    .SCALAR_REG_LEN(64),
    .REG_INDEX_LEN(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .alu_result(alu_result),
    .sign_bits(sign_bits),
    .pc(pc),
    .imm(imm),
    .op_kind(op_kind),
    .branch_cond(branch_cond),
    .rd(rd),
    .rd_write(rd_write),
    .rf_we(rf_we),
    .rf_rd(rf_rd),
    .rf_data(rf_data),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr(mem_addr),
    .instret(instret),
    .err(err)
  );

  function automatic bit exp_taken(
    input logic [1:0] c,
    input logic [1:0] s
  );
    case (c)
      2'd0:    return s == S_ZERO;
      2'd1:    return s != S_ZERO;
      2'd2:    return s == S_NEG;
      default: return (s == S_POS) || (s == S_ZERO);
    endcase
  endfunction

  task automatic drive(
    input logic [2:0]  op,
    input logic [1:0]  c,
    input logic [1:0]  s,
    input logic [31:0] p,
    input logic [63:0] im,
    input logic [63:0] alu,
    input logic [4:0]  r,
    input logic        w
  );
    in_valid    = 1'b1;
    op_kind     = op;
    branch_cond = c;
    sign_bits   = s;
    pc          = p;
    imm         = im;
    alu_result  = alu;
    rd          = r;
    rd_write    = w;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic push(
    input bit          we,
    input logic [4:0]  r,
    input logic [63:0] d,
    input bit          redir,
    input logic [31:0] rpc,
    input bit          e
  );
    ev_t ev;
    ev.we    = we;
    ev.rd    = r;
    ev.data  = d;
    ev.redir = redir;
    ev.rpc   = rpc;
    ev.err   = e;
    sb.push_back(ev);
  endtask

  // Advance to the next negedge and drain any retire event.
  task automatic tick();
    ev_t e;
    bit  bad;
    @(negedge clk);
    if (rf_we || redirect || err) begin
      checks++;
      if (rf_we) we_pulses++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected we=%b rd=%0d redirect=%b err=%b required no event",
                 rf_we, rf_rd, redirect, err);
      end else begin
        e   = sb.pop_front();
        bad = (rf_we !== e.we) || (redirect !== e.redir) ||
              (err !== e.err) ||
              (e.we && ((rf_rd !== e.rd) || (rf_data !== e.data))) ||
              (e.redir && (redirect_pc !== e.rpc));
        if (bad) begin
          errors++;
          $display("FAIL sb_event got we=%b rd=%0d data=%h redir=%b pc=%h err=%b required we=%b rd=%0d data=%h redir=%b pc=%h err=%b",
                   rf_we, rf_rd, rf_data, redirect, redirect_pc, err,
                   e.we, e.rd, e.data, e.redir, e.rpc, e.err);
        end
      end
    end
  endtask

  task automatic chk_instret(input string name);
    checks++;
    if (instret !== exp_instret) begin
      errors++;
      $display("FAIL %s instret got=%0d required=%0d",
               name, instret, exp_instret);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if ({in_ready, rf_we, redirect, mem_valid, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b required=00000",
               {in_ready, rf_we, redirect, mem_valid, err});
    end
    chk_instret("reset");
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_empty_ready got=%b required=1", in_ready);
    end
  endtask

  task automatic test_arith();
    drive(OP_ARITH, 2'd0, S_POS, 32'h0, 64'h0,
          64'hFFFF_FFFF_FFFF_FFFE, 5'd5, 1'b1);
    push(1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE, 0, 32'h0, 0);
    exp_instret++;
    tick();
    idle();
    tick();
    chk_instret("arith");
  endtask

  task automatic test_branch();
    drive(OP_BRANCH, 2'd2, S_NEG, 32'h100,
          64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 5'd0, 1'b0);
    push(0, 5'd0, 64'h0, 1, 32'hF8, 0);
    exp_instret++;
    tick();
    idle();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL blt_redirect_ready got=%b required=0", in_ready);
    end
    tick();
    checks++;
    if ({in_ready, redirect} !== 2'b00) begin
      errors++;
      $display("FAIL blt_flush got=%b required=00",
               {in_ready, redirect});
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL blt_empty_ready got=%b required=1", in_ready);
    end
    chk_instret("blt_taken");
    drive(OP_BRANCH, 2'd2, S_POS, 32'h100,
          64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 5'd0, 1'b0);
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL blt_not_taken_ready got=%b required=1", in_ready);
    end
    drive(OP_ARITH, 2'd0, S_POS, 32'h104, 64'h0, 64'h55, 5'd7, 1'b1);
    push(1, 5'd7, 64'h55, 0, 32'h0, 0);
    exp_instret += 2;
    tick();
    idle();
    tick();
    chk_instret("blt_not_taken");
  endtask

  task automatic test_branch_table();
    for (int c = 0; c < 4; c++) begin
      for (int s = 0; s < 3; s++) begin
        logic [1:0] cv;
        logic [1:0] sv;
        bit         tk;
        cv = c[1:0];
        sv = s[1:0];
        tk = exp_taken(cv, sv);
        drive(OP_BRANCH, cv, sv, 32'h1000, 64'h20, 64'h0, 5'd0, 1'b0);
        if (tk) push(0, 5'd0, 64'h0, 1, 32'h1020, 0);
        exp_instret++;
        tick();
        idle();
        checks++;
        if (in_ready !== !tk) begin
          errors++;
          $display("FAIL branch_c%0d_s%0d in_ready got=%b required=%b",
                   c, s, in_ready, !tk);
        end
        tick();
        tick();
      end
    end
    chk_instret("branch_table");
  endtask

  task automatic test_jumps();
    drive(OP_JALR, 2'd0, S_POS, 32'h200, 64'h0, 64'h1235, 5'd1, 1'b1);
    push(1, 5'd1, 64'h204, 1, 32'h1234, 0);
    exp_instret++;
    tick();
    idle();
    tick();
    tick();
    drive(OP_JAL, 2'd0, S_POS, 32'hFFFF_FFFC, 64'h0, 64'h80, 5'd3, 1'b1);
    push(1, 5'd3, 64'h0, 1, 32'h80, 0);
    exp_instret++;
    tick();
    idle();
    tick();
    tick();
    chk_instret("jumps");
  endtask

  task automatic test_mem();
    mem_ready = 1'b0;
    drive(OP_MEM, 2'd0, S_POS, 32'h300, 64'h0,
          64'hABCD_0000_0000_0040, 5'd4, 1'b1);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mem_valid, in_ready} !== 2'b10 || mem_addr !== 32'h40) begin
        errors++;
        $display("FAIL mem_stall_%0d valid=%b ready=%b addr=%h required 1 0 00000040",
                 i, mem_valid, in_ready, mem_addr);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({mem_valid, in_ready} !== 2'b11 || mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL mem_accept valid=%b ready=%b addr=%h required 1 1 00000040",
               mem_valid, in_ready, mem_addr);
    end
    exp_instret++;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL mem_done valid=%b required=0", mem_valid);
    end
    chk_instret("mem");
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = we_pulses;
    drive(OP_ARITH, 2'd0, S_POS, 32'h400, 64'h0, 64'h11, 5'd2, 1'b1);
    push(1, 5'd2, 64'h11, 0, 32'h0, 0);
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_1 got=%b required=1", in_ready);
    end
    drive(OP_ARITH, 2'd0, S_POS, 32'h404, 64'h0, 64'h22, 5'd0, 1'b1);
    tick();
    checks++;
    if (in_ready !== 1'b1 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL b2b_x0 ready=%b we=%b required 1 0",
               in_ready, rf_we);
    end
    drive(OP_ARITH, 2'd0, S_POS, 32'h408, 64'h0, 64'h33, 5'd9, 1'b1);
    push(1, 5'd9, 64'h33, 0, 32'h0, 0);
    tick();
    idle();
    tick();
    exp_instret += 3;
    chk_instret("b2b");
    checks++;
    if (we_pulses - w0 != 2) begin
      errors++;
      $display("FAIL b2b_we_pulses got=%0d required=2", we_pulses - w0);
    end
  endtask

  task automatic test_random_stream();
    for (int i = 0; i < 24; i++) begin
      logic [4:0]  r;
      logic [63:0] d;
      if ($urandom_range(0, 3) != 0) begin
        r = 5'($urandom_range(0, 31));
        d = {$urandom, $urandom};
        drive(OP_ARITH, 2'd0, S_POS, 32'h500, 64'h0, d, r, 1'b1);
        if (r != 5'd0) push(1, r, d, 0, 32'h0, 0);
        exp_instret++;
      end else begin
        idle();
      end
      tick();
    end
    idle();
    tick();
    chk_instret("random_stream");
  endtask

  task automatic test_reset_mid_mem();
    mem_ready = 1'b0;
    drive(OP_MEM, 2'd0, S_POS, 32'h600, 64'h0, 64'h80, 5'd0, 1'b0);
    tick();
    idle();
    checks++;
    if (mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL rmm_pre_valid got=%b required=1", mem_valid);
    end
    rst = 1'b1;
    mem_ready = 1'b1;
    tick();
    checks++;
    if ({in_ready, mem_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rmm_in_rst ready/valid got=%b required=00",
               {in_ready, mem_valid});
    end
    rst = 1'b0;
    mem_ready = 1'b0;
    exp_instret = 64'd0;
    tick();
    checks++;
    if ({rf_we, redirect, mem_valid, err} !== 4'b0 ||
        mem_addr !== 32'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmm_after got=%b addr=%h ready=%b required 0000 0 1",
               {rf_we, redirect, mem_valid, err}, mem_addr, in_ready);
    end
    chk_instret("rmm_after");
    drive(3'd6, 2'd0, S_POS, 32'h700, 64'h0, 64'h99, 5'd3, 1'b1);
    push(0, 5'd0, 64'h0, 0, 32'h0, 1);
    tick();
    idle();
    tick();
    chk_instret("illegal");
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    alu_result  = '0;
    sign_bits   = '0;
    pc          = '0;
    imm         = '0;
    op_kind     = '0;
    branch_cond = '0;
    rd          = '0;
    rd_write    = 1'b0;
    mem_ready   = 1'b0;
    test_reset();
    test_arith();
    test_branch();
    test_branch_table();
    test_jumps();
    test_mem();
    test_back_to_back();
    test_random_stream();
    test_reset_mid_mem();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
